// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and digit helpers for the 7-segment display controller.
package seg7_pkg;

    localparam logic [3:0]  BLANK_CODE  = 4'hF;
    localparam int unsigned BIN_W       = 14;
    localparam int unsigned BCD_W       = 16;
    localparam int unsigned SR_W        = BIN_W + BCD_W;
    localparam int unsigned DEF_MAX_VAL = 9999;
    localparam int unsigned ITERS       = BIN_W;

    typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_e;

    // One double-dabble iteration: +3 on every BCD nibble >= 5, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 4; i++) begin
            if (t[BIN_W+4*i +: 4] >= 4'd5) begin
                t[BIN_W+4*i +: 4] = t[BIN_W+4*i +: 4] + 4'd3;
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd,
                                                       input logic en);
        logic [BCD_W-1:0] r;
        r = bcd;
        if (en) begin
            if (bcd[15:12] == 4'd0) r[15:12] = BLANK_CODE;
            if (bcd[15:8] == 8'd0)  r[11:8]  = BLANK_CODE;
            if (bcd[15:4] == 12'd0) r[7:4]   = BLANK_CODE;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// Iterative double-dabble converter: one bit per clock, BIN_W clocks per conversion.
module seg7_bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] value,
    output logic             busy,
    output logic             valid,
    output logic [BCD_W-1:0] bcd
);

    logic [SR_W-1:0] sr_q;
    logic [3:0]      cnt_q;
    logic            busy_q;
    logic            valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start && !busy_q) begin
                sr_q   <= {{BCD_W{1'b0}}, value};
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sr_q  <= dabble_step(sr_q);
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(ITERS - 1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = sr_q[BIN_W +: BCD_W];

endmodule

// File: rtl/seg7_disp_ctrl.sv
// Display controller: load handshake, saturation, BCD conversion, leading-zero blanking, blink.
module seg7_disp_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned BLINK_DIV_W = 24,
    parameter int unsigned MAX_VAL     = DEF_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] val_in,
    input  logic             load,
    input  logic             blank_lz,
    input  logic             blink_en,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       digit3,
    output logic [3:0]       digit2,
    output logic [3:0]       digit1,
    output logic [3:0]       digit0
);

    state_e                 state_q;
    logic [3:0]             iter_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic                   ovf_pend_q;
    logic [BCD_W-1:0]       disp_q;
    logic [BLINK_DIV_W-1:0] blink_q;

    logic                   over;
    logic [BIN_W-1:0]       sat_val;
    logic                   accept;
    logic                   eng_busy;
    logic                   eng_valid;
    logic [BCD_W-1:0]       eng_bcd;
    logic                   hide;

    assign over    = 32'(val_in) > MAX_VAL;
    assign sat_val = over ? BIN_W'(MAX_VAL) : val_in;
    assign accept  = (state_q == IDLE) && load && !eng_busy;

    seg7_bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .value (sat_val),
        .busy  (eng_busy),
        .valid (eng_valid),
        .bcd   (eng_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            iter_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ovf_pend_q <= over;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    // Tracks the engine's iteration so UPDATE lands on the edge its result is ready.
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'(ITERS - 1)) state_q <= UPDATE;
                end
                UPDATE: begin
                    if (eng_valid) disp_q <= blank_leading(eng_bcd, blank_lz);
                    ovf_q   <= ovf_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
        end else if (blink_en) begin
            blink_q <= blink_q + BLINK_DIV_W'(1);
        end else begin
            blink_q <= '0;
        end
    end

    assign hide   = blink_en && blink_q[BLINK_DIV_W-1];
    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digit3 = hide ? BLANK_CODE : disp_q[15:12];
    assign digit2 = hide ? BLANK_CODE : disp_q[11:8];
    assign digit1 = hide ? BLANK_CODE : disp_q[7:4];
    assign digit0 = hide ? BLANK_CODE : disp_q[3:0];

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// Self-checking bench for seg7_disp_ctrl: vector table plus scoreboard on done pulses.
module tb_seg7_disp_ctrl;

    logic        clk;
    logic        rst;
    logic [13:0] val_in;
    logic        load;
    logic        blank_lz;
    logic        blink_en;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [3:0]  digit3;
    logic [3:0]  digit2;
    logic [3:0]  digit1;
    logic [3:0]  digit0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [13:0] val;
        logic        blz;
        logic [15:0] exp_digits;
        logic        exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] digits;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    seg7_disp_ctrl #(
        .BLINK_DIV_W (4),
        .MAX_VAL     (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .val_in   (val_in),
        .load     (load),
        .blank_lz (blank_lz),
        .blink_en (blink_en),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .digit3   (digit3),
        .digit2   (digit2),
        .digit1   (digit1),
        .digit0   (digit0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_digits", 32'({digit3, digit2, digit1, digit0}), 32'(mon_e.digits));
                chk("sb_ovf", 32'(ovf), 32'(mon_e.ovf));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is seen.
    // inj != 0 fires a 5678 load on that cycle, which must be ignored while busy.
    task automatic run_conv(input logic [13:0] v, input logic blz, input logic [15:0] ed,
                            input logic eo, input int inj);
        int cyc;
        int bcnt;
        bit seen;
        exp_t e;
        val_in   = v;
        blank_lz = blz;
        load     = 1'b1;
        e.digits = ed;
        e.ovf    = eo;
        sbq.push_back(e);
        cyc  = 0;
        bcnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
            if (cyc == 1) load = 1'b0;
            if (inj != 0 && cyc == inj) begin
                val_in = 14'd5678;
                load   = 1'b1;
            end
            if (inj != 0 && cyc == inj + 1) load = 1'b0;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("latency", 32'(cyc - 1), 32'd15);
            chk("busy_cycles", 32'(bcnt), 32'd15);
        end else if (sbq.size() > 0) begin
            void'(sbq.pop_back());
        end
    endtask

    initial begin
        vec_t vecs[10];
        int   dcount;
        logic vis;

        vecs[0] = '{14'd1234,  1'b0, 16'h1234, 1'b0};
        vecs[1] = '{14'd7,     1'b1, 16'hFFF7, 1'b0};
        vecs[2] = '{14'd0,     1'b1, 16'hFFF0, 1'b0};
        vecs[3] = '{14'd1005,  1'b1, 16'h1005, 1'b0};
        vecs[4] = '{14'd12000, 1'b0, 16'h9999, 1'b1};
        vecs[5] = '{14'd42,    1'b0, 16'h0042, 1'b0};
        vecs[6] = '{14'd10,    1'b1, 16'hFF10, 1'b0};
        vecs[7] = '{14'd100,   1'b1, 16'hF100, 1'b0};
        vecs[8] = '{14'd16383, 1'b1, 16'h9999, 1'b1};
        vecs[9] = '{14'd9999,  1'b1, 16'h9999, 1'b0};

        rst      = 1'b0;
        val_in   = '0;
        load     = 1'b0;
        blank_lz = 1'b0;
        blink_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b1;

        // Idle with changing val_in and no load: nothing moves.
        for (int i = 0; i < 5; i++) begin
            val_in = 14'(i * 1111 + 3);
            @(negedge clk);
        end
        chk("idle_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].val, vecs[i].blz, vecs[i].exp_digits, vecs[i].exp_ovf, 0);
        end

        // Load while busy is dropped; load right after done is accepted.
        run_conv(14'd1234, 1'b0, 16'h1234, 1'b0, 5);
        run_conv(14'd5678, 1'b0, 16'h5678, 1'b0, 0);
        run_conv(14'd1234, 1'b0, 16'h1234, 1'b0, 0);

        // Blink with a 16-cycle period: prescaler counts from 0 once enabled.
        blink_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vis = (((i + 1) >> 3) & 1) == 0;
            chk($sformatf("blink_%0d", i), 32'({digit3, digit2, digit1, digit0}),
                vis ? 32'h1234 : 32'hFFFF);
        end
        chk("blink_busy", 32'(busy), 32'd0);
        chk("blink_ovf", 32'(ovf), 32'd0);
        blink_en = 1'b0;
        @(negedge clk);
        chk("blink_off", 32'({digit3, digit2, digit1, digit0}), 32'h1234);

        // Reset mid-conversion: abort, no done, display back to 0000.
        val_in = 14'd4321;
        load   = 1'b1;
        dcount = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) load = 1'b0;
            if (done) dcount++;
        end
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        chk("abort_digits_after", 32'({digit3, digit2, digit1, digit0}), 32'h0000);
        chk("abort_ovf", 32'(ovf), 32'd0);

        // Display recovers normally after the aborted conversion.
        run_conv(14'd8765, 1'b1, 16'h8765, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_disp_ctrl.md
Name: seg7_disp_ctrl

Overview:
Display controller that feeds the 4-digit multiplexed 7-segment scanner.
- Accepts a 14-bit binary value through a load/busy/done handshake.
- Converts the value to 4 BCD digits with a sequential double-dabble engine.
- Applies saturation, optional leading-zero blanking and optional whole-display blinking.
- Drives the scanner's digit3..digit0 inputs. Blank code 4'hF decodes to all segments off in the scanner.

Parameters:
BLINK_DIV_W, 24, width of the blink prescaler. The display blanks while prescaler MSB = 1, so the blink period is 2^BLINK_DIV_W clk cycles at 50 % duty.
MAX_VAL, 9999, saturation limit. Any input above it displays as 9999 with ovf set.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
val_in  in  14  binary value to display; sampled only on an accepted load
load  in  1  request a conversion; accepted only when busy=0
blank_lz  in  1  leading-zero blanking enable; sampled in the UPDATE cycle
blink_en  in  1  blink enable; live (not sampled)
busy  out  1  conversion in progress
done  out  1  one-cycle pulse when the digit registers update
ovf  out  1  last accepted value exceeded MAX_VAL
digit3  out  4  thousands digit code to the scanner
digit2  out  4  hundreds digit code
digit1  out  4  tens digit code
digit0  out  4  units digit code

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; busy=0, done=0, ovf=0.
  - Stored digits = 0,0,0,0; iteration counter = 0; blink prescaler = 0.
  - Reset asserted mid-conversion aborts it: no done pulse, stored digits return to 0000.
- FSM states: IDLE, CONV, UPDATE.
- IDLE:
  - On load=1 at edge E0: capture min(val_in, MAX_VAL) into the shift register (30 bits: 16 BCD + 14 binary).
  - Set ovf_pending = (val_in > MAX_VAL); clear iteration counter; go to CONV; busy=1.
- CONV: one double-dabble iteration per clock, on edges E1..E14.
  - Each BCD nibble >= 5 gets +3.
  - Then the whole 30-bit register shifts left 1.
  - Counter 0..13; after iteration 14 (edge E14) go to UPDATE.
- UPDATE (edge E15):
  - Write the 4 BCD nibbles to the stored digit registers, applying blanking.
  - ovf <= ovf_pending; done=1 for exactly this one cycle after E15.
  - busy=0 from E15 on; return to IDLE.
  - Total load-to-display latency: 15 clocks. busy is high for 15 cycles.
- load while busy=1: ignored, not queued. val_in changes during CONV have no effect.
- load in the cycle after done (state IDLE): accepted normally. Back-to-back throughput is 1 conversion per 16 cycles.
- Leading-zero blanking (blank_lz=1 at UPDATE):
  - d3 → F if d3=0.
  - d2 → F if d3=0 and d2=0.
  - d1 → F if d3=d2=d1=0.
  - d0 is never blanked; value 0 displays as F,F,F,0.
- Blink:
  - blink_en=1: prescaler increments every clk and wraps freely.
  - blink_en=0: prescaler is held at 0, so the display is visible immediately.
  - Output digitN = F when blink_en=1 and prescaler MSB=1, otherwise stored digitN.
  - Blink does not affect busy/done/ovf or conversion.
- Arithmetic: the saturation compare is done on the full 14 bits. The BCD engine is correct for 0..9999.

Decomposition:
- Package seg7_pkg holds:
  - BLANK_CODE = 4'hF
  - BIN_W = 14, BCD_W = 16
  - Default MAX_VAL
  - FSM state typedef {IDLE, CONV, UPDATE}
- One natural sub-module: seg7_bin2bcd_seq, the iterative double-dabble engine.
  - Interface: start/value in; busy/valid/bcd[15:0] out.
- The top level keeps the handshake, saturation, blanking and blink logic.

Test Plan:
1. Reset pulse → digits 0,0,0,0; busy=0, done=0, ovf=0; none change until load.
2. load val_in=1234, blank_lz=0 → busy high 15 cycles; done pulse 15 clocks after load; digits 1,2,3,4; ovf=0.
3. load 7, blank_lz=1 → F,F,F,7; then load 0 → F,F,F,0; then load 1005 → 1,0,0,5.
4. load 12000 → 9,9,9,9 with ovf=1; next load 42, blank_lz=0 → 0,0,4,2 with ovf=0.
5. load 1234, then load 5678 at cycle 5 while busy → ignored, display 1,2,3,4; load 5678 on the cycle after done → 5,6,7,8.
6. Two checks:
   - rst pulsed at cycle 7 of a conversion → digits 0000, busy=0, no done.
   - With BLINK_DIV_W=4, blink_en=1 showing 1234 → 8 cycles of 1,2,3,4 and 8 cycles of F,F,F,F, repeating. Dropping blink_en restores 1,2,3,4 next cycle.
